// File: rtl/point_dispatcher.sv
// point_dispatcher: steers clustered data points into eight accumulators.
// Each accepted point waits in a single holding register until its target
// accumulator is free, then is driven onto the registered demux outputs
// with a write strobe. Points aimed at clusters outside 1..8 are dropped.
// Optional feature: define DISPATCH_STALL_CNT_EN to count cycles lost
// waiting on busy accumulators (stall_cycles); otherwise it reads 0.
module point_dispatcher #(
  parameter int DATA_WIDTH = 91,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [3:0]            in_cluster,
  input  logic                  in_last,
  input  logic [7:0]            acc_busy,
  output logic [3:0]            demux_index,
  output logic [DATA_WIDTH-1:0] demux_data,
  output logic                  acc_we,
  input  logic [2:0]            cnt_sel,
  output logic [CNT_WIDTH-1:0]  cnt_out,
  output logic                  done,
  output logic                  err_drop,
  output logic [15:0]           stall_cycles
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                r_state;
  state_t                w_stateNext;

  logic                  r_holdValid;
  logic [DATA_WIDTH-1:0] r_holdData;
  logic [3:0]            r_holdIdx;
  logic                  r_holdLast;

  logic [CNT_WIDTH-1:0]  r_count [8];

  logic                  w_idxRoutable;
  logic [2:0]            w_target;
  logic                  w_targetBusy;
  logic                  w_issue;
  logic                  w_drop;
  logic                  w_handshake;
  logic                  w_restart;

  assign w_idxRoutable = (r_holdIdx != 4'd0) && (r_holdIdx <= 4'd8);
  assign w_target      = r_holdIdx[2:0] - 3'd1;
  assign w_targetBusy  = acc_busy[w_target];
  assign w_issue       = (r_state == RUN) && r_holdValid && w_idxRoutable && !w_targetBusy;
  assign w_drop        = (r_state == RUN) && r_holdValid && !w_idxRoutable;
  assign w_handshake   = in_valid && in_ready;
  assign w_restart     = start && (r_state != RUN);
  assign cnt_out       = r_count[cnt_sel];

  // State register; reset parks the dispatcher in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  // Next state plus the combinational ready/done outputs.
  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_stateNext = RUN;
      end
      RUN: begin
        in_ready = !r_holdValid || w_issue || w_drop;
        if ((w_issue || w_drop) && r_holdLast) w_stateNext = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_stateNext = RUN;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Holding register: a new point may replace one leaving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_holdValid <= 1'b0;
      r_holdData  <= '0;
      r_holdIdx   <= '0;
      r_holdLast  <= 1'b0;
    end else if (w_handshake) begin
      r_holdValid <= 1'b1;
      r_holdData  <= in_data;
      r_holdIdx   <= in_cluster;
      r_holdLast  <= in_last;
    end else if (w_issue || w_drop) begin
      r_holdValid <= 1'b0;
    end
  end

  // Registered demux drive; zeros whenever nothing is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      demux_index <= '0;
      demux_data  <= '0;
      acc_we      <= 1'b0;
    end else begin
      demux_index <= w_issue ? r_holdIdx : 4'd0;
      demux_data  <= w_issue ? r_holdData : '0;
      acc_we      <= w_issue;
    end
  end

  // Per-cluster issue counters, saturating, cleared when a pass starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) r_count[k] <= '0;
    end else if (w_restart) begin
      for (int k = 0; k < 8; k++) r_count[k] <= '0;
    end else if (w_issue && (r_count[w_target] != '1)) begin
      r_count[w_target] <= r_count[w_target] + 1'b1;
    end
  end

  // Sticky flag for points dropped because their cluster is unroutable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            err_drop <= 1'b0;
    else if (w_restart) err_drop <= 1'b0;
    else if (w_drop)    err_drop <= 1'b1;
  end

`ifdef DISPATCH_STALL_CNT_EN
  logic [15:0] r_stall;
  logic        w_stallNow;

  assign w_stallNow   = (r_state == RUN) && r_holdValid && w_idxRoutable && w_targetBusy;
  assign stall_cycles = r_stall;

  // Saturating count of cycles a routable point waited on a busy target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_stall <= '0;
    else if (w_restart)                       r_stall <= '0;
    else if (w_stallNow && (r_stall != '1))   r_stall <= r_stall + 16'd1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_point_dispatcher.sv
// Bench for point_dispatcher: a transaction-level reference (queue of
// waiting points, per-cluster totals) checked every cycle, plus directed
// scenarios with hand-computed expectations and randomized passes.
module tb_point_dispatcher;

  localparam int DW = 91;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [3:0]    in_cluster = '0;
  logic          in_last = 1'b0;
  logic [7:0]    acc_busy = '0;
  logic [3:0]    demux_index;
  logic [DW-1:0] demux_data;
  logic          acc_we;
  logic [2:0]    cnt_sel = '0;
  logic [CW-1:0] cnt_out;
  logic          done;
  logic          err_drop;
  logic [15:0]   stall_cycles;

  int assertCount = 0;
  int failCount = 0;

  point_dispatcher #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_cluster(in_cluster), .in_last(in_last), .acc_busy(acc_busy),
    .demux_index(demux_index), .demux_data(demux_data), .acc_we(acc_we),
    .cnt_sel(cnt_sel), .cnt_out(cnt_out), .done(done),
    .err_drop(err_drop), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference: points waiting to leave, pass phase, totals per cluster.
  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    idx;
    logic          last;
  } point_t;

  point_t        pending[$];
  int            mPhase = 0;        // 0 idle, 1 running, 2 finished
  int            mCount[8] = '{default: 0};
  bit            mErr = 1'b0;
  int            mStall = 0;
  logic [3:0]    mIdx = '0;
  logic [DW-1:0] mData = '0;
  bit            mWe = 1'b0;

  function automatic bit routable(input logic [3:0] idx);
    return (idx >= 4'd1) && (idx <= 4'd8);
  endfunction

  function automatic bit headGoes();
    if (mPhase != 1 || pending.size() == 0) return 1'b0;
    if (!routable(pending[0].idx)) return 1'b0;
    return !acc_busy[int'(pending[0].idx) - 1];
  endfunction

  function automatic bit headDropped();
    return (mPhase == 1) && (pending.size() != 0) && !routable(pending[0].idx);
  endfunction

  function automatic bit modelReady();
    return (mPhase == 1) && ((pending.size() == 0) || headGoes() || headDropped());
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference by one clock edge using the inputs seen at that edge.
  always @(posedge clk or posedge rst) begin : modelProc
    int     prevPhase;
    bit     go;
    bit     drp;
    bit     rdy;
    bit     waitBusy;
    point_t head;
    if (rst) begin
      mPhase = 0;
      pending.delete();
      for (int k = 0; k < 8; k++) mCount[k] = 0;
      mErr = 1'b0;
      mStall = 0;
      mIdx = '0;
      mData = '0;
      mWe = 1'b0;
    end else begin
      prevPhase = mPhase;
      go = headGoes();
      drp = headDropped();
      rdy = modelReady();
      waitBusy = (mPhase == 1) && (pending.size() != 0) && routable(pending[0].idx) && !go;
      mWe = 1'b0;
      mIdx = '0;
      mData = '0;
      if (go) begin
        head = pending.pop_front();
        mWe = 1'b1;
        mIdx = head.idx;
        mData = head.data;
        if (mCount[int'(head.idx) - 1] < CNT_MAX) mCount[int'(head.idx) - 1]++;
        if (head.last) mPhase = 2;
      end else if (drp) begin
        head = pending.pop_front();
        mErr = 1'b1;
        if (head.last) mPhase = 2;
      end
      if (waitBusy && mStall < 65535) mStall++;
      if (rdy && in_valid) pending.push_back('{data: in_data, idx: in_cluster, last: in_last});
      if (prevPhase != 1 && start) begin
        mPhase = 1;
        for (int k = 0; k < 8; k++) mCount[k] = 0;
        mErr = 1'b0;
        mStall = 0;
      end
    end
  end

  // Compare every DUT output against the reference away from the clock edge.
  always @(negedge clk) begin
    int expStall;
`ifdef DISPATCH_STALL_CNT_EN
    expStall = mStall;
`else
    expStall = 0;
`endif
    if (rst) begin
      checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
      checkOutput("rst_acc_we", 128'(acc_we), 128'(0));
      checkOutput("rst_demux_index", 128'(demux_index), 128'(0));
      checkOutput("rst_demux_data", 128'(demux_data), 128'(0));
      checkOutput("rst_done", 128'(done), 128'(0));
      checkOutput("rst_err_drop", 128'(err_drop), 128'(0));
      checkOutput("rst_stall", 128'(stall_cycles), 128'(0));
    end else begin
      checkOutput("in_ready", 128'(in_ready), 128'(modelReady()));
      checkOutput("acc_we", 128'(acc_we), 128'(mWe));
      checkOutput("demux_index", 128'(demux_index), 128'(mIdx));
      checkOutput("demux_data", 128'(demux_data), 128'(mData));
      checkOutput("cnt_out", 128'(cnt_out), 128'(mCount[cnt_sel]));
      checkOutput("done", 128'(done), 128'(mPhase == 2));
      checkOutput("err_drop", 128'(err_drop), 128'(mErr));
      checkOutput("stall_cycles", 128'(stall_cycles), 128'(expStall));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [DW-1:0] d, input logic l);
    in_valid = v;
    in_cluster = c;
    in_data = d;
    in_last = l;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [DW-1:0] randData();
    logic [95:0] raw;
    raw = {$urandom(), $urandom(), $urandom()};
    return raw[DW-1:0];
  endfunction

  initial begin
    int expStall;
    bit lastSent;
    int cyc;
    int wd;
    logic [3:0] cl;
    logic v;
    logic l;

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_ready", 128'(in_ready), 128'(0));
    checkOutput("reset_done", 128'(done), 128'(0));
    checkOutput("reset_cnt", 128'(cnt_out), 128'(0));

    // Single point to cluster 3, the last of its pass.
    pulseStart();
    applyStimulus(1'b1, 4'd3, DW'(8'h5A), 1'b1);
    #1 checkOutput("s1_ready", 128'(in_ready), 128'(1));
    tick();
    applyStimulus(1'b0, 4'd0, '0, 1'b0);
    #1 checkOutput("s1_we_early", 128'(acc_we), 128'(0));
    tick();
    checkOutput("s1_we", 128'(acc_we), 128'(1));
    checkOutput("s1_index", 128'(demux_index), 128'(3));
    checkOutput("s1_data", 128'(demux_data), 128'(8'h5A));
    tick();
    checkOutput("s1_we_after", 128'(acc_we), 128'(0));
    checkOutput("s1_done", 128'(done), 128'(1));
    cnt_sel = 3'd2;
    #1 checkOutput("s1_cnt", 128'(cnt_out), 128'(1));

    // Back-to-back stream to clusters 1..8.
    pulseStart();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 4'(i), DW'(i * 17), i == 8);
      #1 checkOutput("s2_ready", 128'(in_ready), 128'(1));
      tick();
      if (i >= 2) begin
        checkOutput("s2_we", 128'(acc_we), 128'(1));
        checkOutput("s2_index", 128'(demux_index), 128'(i - 1));
      end
    end
    applyStimulus(1'b0, 4'd0, '0, 1'b0);
    tick();
    checkOutput("s2_we_last", 128'(acc_we), 128'(1));
    checkOutput("s2_index_last", 128'(demux_index), 128'(8));
    checkOutput("s2_data_last", 128'(demux_data), 128'(136));
    checkOutput("s2_done", 128'(done), 128'(1));
    for (int s = 0; s < 8; s++) begin
      cnt_sel = 3'(s);
      #1 checkOutput("s2_cnt", 128'(cnt_out), 128'(1));
    end

    // Cluster 5 point held behind a busy accumulator for five cycles.
    pulseStart();
    acc_busy = 8'h10;
    applyStimulus(1'b1, 4'd5, DW'(16'hBEEF), 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, '0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      #1;
      checkOutput("s3_ready_busy", 128'(in_ready), 128'(0));
      checkOutput("s3_we_busy", 128'(acc_we), 128'(0));
      tick();
    end
    acc_busy = 8'h00;
    tick();
    checkOutput("s3_we", 128'(acc_we), 128'(1));
    checkOutput("s3_index", 128'(demux_index), 128'(5));
    checkOutput("s3_data", 128'(demux_data), 128'(16'hBEEF));
`ifdef DISPATCH_STALL_CNT_EN
    expStall = 5;
`else
    expStall = 0;
`endif
    checkOutput("s3_stall", 128'(stall_cycles), 128'(expStall));
    tick();
    checkOutput("s3_single_issue", 128'(acc_we), 128'(0));

    // Unroutable clusters 0 and 12 are dropped.
    pulseStart();
    applyStimulus(1'b1, 4'd0, DW'(1), 1'b0);
    tick();
    applyStimulus(1'b1, 4'd12, DW'(2), 1'b1);
    #1 checkOutput("s4_ready", 128'(in_ready), 128'(1));
    tick();
    applyStimulus(1'b0, 4'd0, '0, 1'b0);
    checkOutput("s4_we", 128'(acc_we), 128'(0));
    checkOutput("s4_err", 128'(err_drop), 128'(1));
    tick();
    checkOutput("s4_done", 128'(done), 128'(1));
    checkOutput("s4_we2", 128'(acc_we), 128'(0));
    for (int s = 0; s < 8; s++) begin
      cnt_sel = 3'(s);
      #1 checkOutput("s4_cnt", 128'(cnt_out), 128'(0));
    end

    // Randomized passes with busy accumulators and stray clusters.
    for (int p = 0; p < 15; p++) begin
      pulseStart();
      lastSent = 1'b0;
      cyc = 0;
      while (!lastSent && cyc < 200) begin
        v = ($urandom_range(0, 3) != 0);
        cl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
        l = (cyc >= 40) || ($urandom_range(0, 15) == 0);
        applyStimulus(v, cl, randData(), l);
        acc_busy = 8'($urandom() & $urandom());
        cnt_sel = 3'($urandom_range(0, 7));
        start = ($urandom_range(0, 19) == 0);
        #1;
        if (v && l && in_ready) lastSent = 1'b1;
        tick();
        cyc++;
      end
      start = 1'b0;
      checkOutput("rnd_last_accepted", 128'(lastSent), 128'(1));
      applyStimulus(1'b0, 4'd0, '0, 1'b0);
      wd = 0;
      while (!done && wd < 100) begin
        acc_busy = 8'($urandom() & $urandom());
        tick();
        wd++;
      end
      checkOutput("rnd_pass_done", 128'(done), 128'(1));
    end
    acc_busy = 8'h00;

    // Saturation of the cluster 1 counter.
    pulseStart();
    for (int i = 0; i <= CNT_MAX + 1; i++) begin
      applyStimulus(1'b1, 4'd1, DW'(i), i == CNT_MAX + 1);
      tick();
    end
    applyStimulus(1'b0, 4'd0, '0, 1'b0);
    tick();
    tick();
    cnt_sel = 3'd0;
    #1;
    checkOutput("s5_cnt_sat", 128'(cnt_out), 128'(16'hFFFF));
    checkOutput("s5_done", 128'(done), 128'(1));

    // Reset in the middle of traffic.
    pulseStart();
    cnt_sel = 3'd1;
    applyStimulus(1'b1, 4'd2, DW'(8'h11), 1'b0);
    tick();
    applyStimulus(1'b1, 4'd4, DW'(8'h22), 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, '0, 1'b0);
    checkOutput("s6_we_before", 128'(acc_we), 128'(1));
    checkOutput("s6_cnt_before", 128'(cnt_out), 128'(1));
    rst = 1'b1;
    #1;
    checkOutput("s6_ready", 128'(in_ready), 128'(0));
    checkOutput("s6_we", 128'(acc_we), 128'(0));
    checkOutput("s6_index", 128'(demux_index), 128'(0));
    checkOutput("s6_data", 128'(demux_data), 128'(0));
    checkOutput("s6_done", 128'(done), 128'(0));
    checkOutput("s6_cnt", 128'(cnt_out), 128'(0));
    tick();
    rst = 1'b0;
    pulseStart();
    for (int s = 0; s < 8; s++) begin
      cnt_sel = 3'(s);
      #1 checkOutput("s6_cnt_after", 128'(cnt_out), 128'(0));
    end
    tick();
    checkOutput("s6_no_ghost", 128'(acc_we), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
